countdown_timer: RTL and testbench
==================================

// Module: countdown_timer
// PURPOSE
//   Parametrised countdown timer: divides clk into a tick period and counts a loaded
//   number of ticks, with a blink output, tick/done pulses, pause, abort and periodic
//   auto-reload modes. It is the generalised successor of the fixed 1 s x 4 game-phase
//   counter. FSM/game-control logic instantiates one per timed phase (countdown, blink, timeout).
// PARAMETERS
//   TICK_DIV   100_000_000  clk cycles per tick; must be >= 2 (1 s at 100 MHz)
//   CNT_W      4            width of tick count / remaining
// PORTS
//   clk         in   1       system clock, all logic on posedge
//   rst_n       in   1       reset, synchronous, active-low
//   start       in   1       level sampled each cycle; (re)starts a run from load_ticks
//   load_ticks  in   CNT_W   ticks per run, sampled only when start accepted
//   mode        in   1       0 = one-shot, 1 = periodic (auto-reload); sampled with start
//   pause       in   1       level; freezes timing while high
//   abort       in   1       level; cancels run, returns to IDLE
//   busy        out  1       high in RUN or HOLD
//   tick        out  1       1-cycle pulse at end of each tick period
//   done        out  1       1-cycle pulse when remaining reaches 0
//   flash       out  1       50% blink at tick rate while RUN/HOLD, else 0
//   remaining   out  CNT_W   ticks left in current run
// BEHAVIOUR
//   - Reset (rst_n=0 at posedge): state IDLE, prescaler 0, all outputs 0, latched count/mode 0.
//   - All outputs registered. States: IDLE, RUN, HOLD.
//   - Priority per cycle: rst_n > abort > start > pause > counting.
//   - abort: any state -> IDLE next cycle; remaining, prescaler, flash cleared; no done, no tick.
//   - start accepted in any state (restart if busy): latch load_ticks->remaining and reload
//     register, latch mode, prescaler<=0, state RUN. start with load_ticks==0: stay/return
//     IDLE, done pulses next cycle, busy stays 0.
//   - Held start: restart repeats each cycle (prescaler never advances); callers pulse start.
//   - RUN: prescaler increments 0..TICK_DIV-1 and wraps to 0. On wrap cycle: tick=1 next
//     cycle, remaining decrements. First tick pulse exactly TICK_DIV cycles after busy rises.
//   - flash = 1 while prescaler < TICK_DIV/2 (integer divide), else 0; i.e. high in the
//     first half of every tick period, starting high on the cycle busy rises.
//   - remaining 1->0 on a wrap: tick and done pulse in the same cycle. One-shot: state IDLE,
//     busy=0, flash=0, remaining=0. Periodic: remaining reloads from reload register
//     (never shows 0), stays RUN, prescaler continues from 0 without a gap.
//   - pause=1 in RUN -> HOLD: prescaler, remaining, flash frozen; no tick/done.
//     pause=0 in HOLD -> RUN, resumes from frozen prescaler (no lost or extra cycles).
//     pause in IDLE ignored. start while pause=1: restart accepted, enters HOLD.
//   - tick/done never assert in IDLE or HOLD except the load_ticks==0 done.
//   - Arithmetic: prescaler width $clog2(TICK_DIV); remaining unsigned, never wraps below 0.
// STRUCTURE
//   - Shared package (timer_pkg): state encoding localparams ST_IDLE/ST_RUN/ST_HOLD,
//     default TICK_DIV for 100 MHz board clock.
//   - Sub-module tick_prescaler (clk, rst_n, clr, en -> wrap, half): modulo-TICK_DIV counter
//     with clear and enable; half = count < TICK_DIV/2. FSM, counters, outputs in top.
// TESTING (TICK_DIV=10, CNT_W=4)
//   - One-shot: start, load=3, mode=0 -> busy next cycle; tick at +10,+20,+30; done with
//     3rd tick; remaining 3,2,1,0; busy=0 after; flash high 5 cycles / low 5 cycles.
//   - Periodic: load=2, mode=1, run 60 cycles -> 6 ticks, done every 20 cycles,
//     remaining 2,1,2,1..., busy never drops.
//   - Pause: load=2, pause=1 for 7 cycles at prescaler=4 -> first tick delayed to +17;
//     flash/remaining frozen during HOLD.
//   - Abort at remaining=1, prescaler=8 -> IDLE next cycle, no tick/done, outputs 0;
//     abort+start same cycle -> abort wins.
//   - Restart mid-run at prescaler=6 with load=5 -> remaining=5, next tick +10 after start.
//   - load=0 start -> done pulse next cycle, busy stays 0; rst_n=0 mid-RUN -> all outputs 0.

Source files
------------

// File: rtl/timer_pkg.sv
// timer_pkg: shared state encoding and board-clock defaults for countdown timers
package timer_pkg;
  localparam int DEF_TICK_DIV = 100_000_000;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HOLD} state_e;
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: modulo-TICK_DIV cycle counter with clear/enable and half-period flag
module tick_prescaler
  import timer_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic wrap,
  output logic half
);
  localparam int W = $clog2(TICK_DIV);
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);
  localparam logic [W-1:0] HALF = W'(TICK_DIV / 2);
  logic [W-1:0] cnt_q, cnt_d;
  // next count: clear wins, then hold when disabled, else count and wrap at LAST
  always_comb cnt_d = clr ? '0 : !en ? cnt_q : (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  // wrap marks the last cycle of a period; half refers to the value loaded next cycle
  // so the registered flash in the parent lines up with the counter
  assign wrap = cnt_q == LAST;
  assign half = cnt_d < HALF;
  // count register
  always_ff @(posedge clk)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/countdown_timer.sv
// countdown_timer: counts load_ticks tick periods with pause, abort and auto-reload
module countdown_timer
  import timer_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] load_ticks,
  input  logic             mode,
  input  logic             pause,
  input  logic             abort,
  output logic             busy,
  output logic             tick,
  output logic             done,
  output logic             flash,
  output logic [CNT_W-1:0] remaining
);
  state_e state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d, reload_q, reload_d;
  logic mode_q, mode_d, tick_q, tick_d, done_q, done_d, flash_q, flash_d;
  logic clr, en, wrap, half, last;
  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_pre (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .en   (en),
    .wrap (wrap),
    .half (half)
  );
  assign last = rem_q == CNT_W'(1);
  // next state, count and pulses; priority abort > start > pause > counting
  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    reload_d = reload_q;
    mode_d   = mode_q;
    tick_d   = 1'b0;
    done_d   = 1'b0;
    clr      = 1'b0;
    en       = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
      rem_d   = '0;
      clr     = 1'b1;
    end else if (start) begin
      rem_d    = load_ticks;
      reload_d = load_ticks;
      mode_d   = mode;
      clr      = 1'b1;
      done_d   = load_ticks == '0;
      state_d  = (load_ticks == '0) ? ST_IDLE : pause ? ST_HOLD : ST_RUN;
    end else if (state_q != ST_IDLE) begin
      state_d = pause ? ST_HOLD : ST_RUN;
      en      = !pause;
      if (wrap && !pause) begin
        tick_d  = 1'b1;
        done_d  = last;
        rem_d   = !last ? rem_q - 1'b1 : mode_q ? reload_q : '0;
        state_d = (last && !mode_q) ? ST_IDLE : ST_RUN;
      end
    end
  end
  assign flash_d = (state_d != ST_IDLE) && half;
  // state and output registers
  always_ff @(posedge clk)
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      rem_q    <= '0;
      reload_q <= '0;
      mode_q   <= 1'b0;
      tick_q   <= 1'b0;
      done_q   <= 1'b0;
      flash_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      reload_q <= reload_d;
      mode_q   <= mode_d;
      tick_q   <= tick_d;
      done_q   <= done_d;
      flash_q  <= flash_d;
    end
  assign busy      = state_q != ST_IDLE;
  assign tick      = tick_q;
  assign done      = done_q;
  assign flash     = flash_q;
  assign remaining = rem_q;
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed vectors and corner sequences for countdown_timer
module tb_countdown_timer;
  logic clk, rst_n, start, mode, pause, abort;
  logic [3:0] load_ticks;
  logic busy, tick, done, flash;
  logic [3:0] remaining;
  logic [7:0] outs;
  int checks, errors, ticks;

  countdown_timer #(.TICK_DIV(10), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .load_ticks(load_ticks), .mode(mode),
    .pause(pause), .abort(abort), .busy(busy), .tick(tick), .done(done),
    .flash(flash), .remaining(remaining)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign outs = {busy, tick, done, flash, remaining};

  typedef struct {
    logic rn, st;
    logic [3:0] ld;
    logic md, ps, ab;
    logic [7:0] ex;
  } vec_t;
  vec_t tv[11];

  function automatic logic [7:0] o(input logic b, t, d, f, input logic [3:0] r);
    return {b, t, d, f, r};
  endfunction

  task automatic chk(input string nm, input int i, input logic [7:0] exp);
    checks++;
    if (outs !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %b expected %b (busy,tick,done,flash,rem[3:0])", nm, i, outs, exp);
    end
  endtask

  task automatic go(input logic s, input logic [3:0] l, input logic m, p, a);
    start = s; load_ticks = l; mode = m; pause = p; abort = a;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0; errors = 0; ticks = 0;
    rst_n = 1'b0; start = 1'b0; load_ticks = '0; mode = 1'b0; pause = 1'b0; abort = 1'b0;
    tv[0]  = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, o(0, 0, 0, 0, 0)};
    tv[1]  = '{1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, o(0, 0, 0, 0, 0)};
    tv[2]  = '{1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, o(0, 0, 1, 0, 0)};
    tv[3]  = '{1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, o(0, 0, 0, 0, 0)};
    tv[4]  = '{1'b1, 1'b1, 4'd5, 1'b0, 1'b0, 1'b1, o(0, 0, 0, 0, 0)};
    tv[5]  = '{1'b1, 1'b1, 4'd3, 1'b0, 1'b1, 1'b0, o(1, 0, 0, 1, 3)};
    tv[6]  = '{1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, o(1, 0, 0, 1, 3)};
    tv[7]  = '{1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, o(0, 0, 0, 0, 0)};
    tv[8]  = '{1'b1, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0, o(1, 0, 0, 1, 2)};
    tv[9]  = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, o(0, 0, 0, 0, 0)};
    tv[10] = '{1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, o(0, 0, 0, 0, 0)};
    for (int i = 0; i < 11; i++) begin
      rst_n = tv[i].rn;
      go(tv[i].st, tv[i].ld, tv[i].md, tv[i].ps, tv[i].ab);
      chk("table", i, tv[i].ex);
    end
    rst_n = 1'b1;

    go(1, 3, 0, 0, 0);
    chk("oneshot", 0, o(1, 0, 0, 1, 3));
    for (int c = 1; c <= 33; c++) begin
      go(0, 0, 0, 0, 0);
      chk("oneshot", c, c < 30 ? o(1, c % 10 == 0, 0, (c % 10) < 5, 4'(3 - c / 10))
                              : c == 30 ? o(0, 1, 1, 0, 0) : o(0, 0, 0, 0, 0));
    end

    go(1, 2, 1, 0, 0);
    chk("periodic", 0, o(1, 0, 0, 1, 2));
    for (int c = 1; c <= 60; c++) begin
      go(0, 0, 0, 0, 0);
      if (tick) ticks++;
      chk("periodic", c, o(1, c % 10 == 0, c % 20 == 0, (c % 10) < 5, 4'(2 - (c % 20) / 10)));
    end
    checks++;
    if (ticks != 6) begin
      errors++;
      $display("FAIL periodic_ticks: got %0d expected 6", ticks);
    end
    go(0, 0, 0, 0, 1);
    chk("periodic_abort", 0, o(0, 0, 0, 0, 0));

    go(1, 2, 0, 0, 0);
    chk("pause", 0, o(1, 0, 0, 1, 2));
    for (int c = 1; c <= 4; c++) begin
      go(0, 0, 0, 0, 0);
      chk("pause", c, o(1, 0, 0, 1, 2));
    end
    for (int c = 5; c <= 11; c++) begin
      go(0, 0, 0, 1, 0);
      chk("pause_hold", c, o(1, 0, 0, 1, 2));
    end
    for (int c = 12; c <= 25; c++) begin
      go(0, 0, 0, 0, 0);
      chk("pause_resume", c, o(1, c == 17, 0, ((c - 7) % 10) < 5, c < 17 ? 4'd2 : 4'd1));
    end
    go(0, 0, 0, 0, 1);
    chk("abort", 0, o(0, 0, 0, 0, 0));
    go(0, 0, 0, 0, 0);
    chk("abort", 1, o(0, 0, 0, 0, 0));

    go(1, 2, 0, 0, 0);
    for (int c = 1; c <= 6; c++) begin
      go(0, 0, 0, 0, 0);
      chk("restart_pre", c, o(1, 0, 0, c < 5, 2));
    end
    go(1, 5, 0, 0, 0);
    chk("restart", 0, o(1, 0, 0, 1, 5));
    for (int j = 1; j <= 10; j++) begin
      go(0, 0, 0, 0, 0);
      chk("restart", j, o(1, j == 10, 0, (j % 10) < 5, j < 10 ? 4'd5 : 4'd4));
    end
    go(0, 0, 0, 0, 1);
    chk("restart_abort", 0, o(0, 0, 0, 0, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
